ram_single_frame_buffer: RTL and testbench

RAM_SINGLE_FRAME_BUFFER -- requirements
Module: ram_single_frame_buffer

---
 rtl/ram_single_frame_buffer.sv | 160 ++++++++++++++++
 tb/tb_ram_single_frame_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_single_frame_buffer.sv
// Single-frame buffer: fills one frame into an external single-port RAM, then
// drains it in address order through a 3-entry output FIFO.
module ram_single_frame_buffer #(
   parameter int unsigned ADDRESS_WIDTH = 7,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned FRAME_LEN     = 128
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_data,
   output logic                         ram_en,
   output logic                         ram_we,
   output logic [ADDRESS_WIDTH-1:0]     ram_addr,
   output logic signed [DATA_WIDTH-1:0] ram_di,
   input  logic signed [DATA_WIDTH-1:0] ram_do,
   output logic                         frame_done
);

   localparam int unsigned CNT_W      = $clog2(FRAME_LEN + 1);
   localparam int unsigned FIFO_DEPTH = 3;
   localparam int unsigned IDX_W      = 2;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]         FRAME_CNT = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0]         LAST_CNT  = CNT_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(FIFO_DEPTH - 1);

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   state_e                       state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]             reads_issued_q, reads_issued_d;
   logic [CNT_W-1:0]             out_cnt_q, out_cnt_d;
   logic                         in_flight_q, in_flight_d;
   logic [IDX_W-1:0]             fifo_count_q, fifo_count_d;
   logic [IDX_W-1:0]             fifo_wr_idx_q, fifo_wr_idx_d;
   logic [IDX_W-1:0]             fifo_rd_idx_q, fifo_rd_idx_d;
   logic signed [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic signed [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];

   logic fill_hs_c;
   logic issue_c;
   logic push_c;
   logic pop_c;

   // Next-state, RAM control, stream handshakes and output FIFO bookkeeping.
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      reads_issued_d = reads_issued_q;
      out_cnt_d      = out_cnt_q;
      in_flight_d    = 1'b0;
      fifo_count_d   = fifo_count_q;
      fifo_wr_idx_d  = fifo_wr_idx_q;
      fifo_rd_idx_d  = fifo_rd_idx_q;
      fifo_mem_d     = fifo_mem_q;
      ram_en         = 1'b0;
      ram_we         = 1'b0;
      ram_addr       = '0;
      ram_di         = '0;
      frame_done     = 1'b0;

      // Reset forces the idle view on all outputs during the reset cycle.
      s_ready   = (state_q == ST_FILL) || !rst_n;
      fill_hs_c = rst_n && (state_q == ST_FILL) && s_valid;
      m_valid   = rst_n && (fifo_count_q != '0);
      m_data    = m_valid ? fifo_mem_q[fifo_rd_idx_q] : '0;
      pop_c     = m_valid && m_ready;
      push_c    = in_flight_q;
      // Read issue looks only at registered state, so m_ready never reaches ram_en.
      issue_c   = rst_n && (state_q == ST_DRAIN) && (reads_issued_q < FRAME_CNT) &&
                  (({1'b0, fifo_count_q} + {2'b00, in_flight_q}) < 3'd3);

      case (state_q)
         ST_FILL: begin
            if (fill_hs_c) begin
               ram_en   = 1'b1;
               ram_we   = 1'b1;
               ram_addr = wr_ptr_q;
               ram_di   = s_data;
               if (wr_ptr_q == LAST_ADDR) begin
                  wr_ptr_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (issue_c) begin
               ram_en         = 1'b1;
               ram_addr       = rd_ptr_q;
               rd_ptr_d       = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
               reads_issued_d = reads_issued_q + 1'b1;
               in_flight_d    = 1'b1;
            end
            if (pop_c) begin
               if (out_cnt_q == LAST_CNT) begin
                  frame_done     = 1'b1;
                  state_d        = ST_FILL;
                  rd_ptr_d       = '0;
                  reads_issued_d = '0;
                  out_cnt_d      = '0;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      // Read data lands in the FIFO the cycle after the read was issued.
      if (push_c) begin
         fifo_mem_d[fifo_wr_idx_q] = ram_do;
         fifo_wr_idx_d = (fifo_wr_idx_q == LAST_IDX) ? '0 : fifo_wr_idx_q + 1'b1;
      end
      if (pop_c) begin
         fifo_rd_idx_d = (fifo_rd_idx_q == LAST_IDX) ? '0 : fifo_rd_idx_q + 1'b1;
      end
      fifo_count_d = fifo_count_q + IDX_W'(push_c) - IDX_W'(pop_c);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_FILL;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         reads_issued_q <= '0;
         out_cnt_q      <= '0;
         in_flight_q    <= 1'b0;
         fifo_count_q   <= '0;
         fifo_wr_idx_q  <= '0;
         fifo_rd_idx_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         reads_issued_q <= reads_issued_d;
         out_cnt_q      <= out_cnt_d;
         in_flight_q    <= in_flight_d;
         fifo_count_q   <= fifo_count_d;
         fifo_wr_idx_q  <= fifo_wr_idx_d;
         fifo_rd_idx_q  <= fifo_rd_idx_d;
         fifo_mem_q     <= fifo_mem_d;
      end
   end

endmodule

// File: tb/tb_ram_single_frame_buffer.sv
// Testbench for ram_single_frame_buffer: default-size instance plus a small
// 8-sample instance, each backed by a behavioural single-port RAM.
module tb_ram_single_frame_buffer;

   localparam int unsigned AW  = 7;
   localparam int unsigned DW  = 16;
   localparam int unsigned FL  = 128;
   localparam int unsigned SAW = 3;
   localparam int unsigned SFL = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic                 s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
   logic signed [DW-1:0] s_data = '0, m_data, ram_di, ram_do = '0;
   logic                 ram_en, ram_we, frame_done;
   logic [AW-1:0]        ram_addr;

   logic                 sm_s_valid = 1'b0, sm_s_ready, sm_m_valid, sm_m_ready = 1'b0;
   logic signed [DW-1:0] sm_s_data = '0, sm_m_data, sm_ram_di, sm_ram_do = '0;
   logic                 sm_ram_en, sm_ram_we, sm_frame_done;
   logic [SAW-1:0]       sm_ram_addr;

   logic signed [DW-1:0] mem    [2**AW];
   logic signed [DW-1:0] sm_mem [2**SAW];

   int checks = 0;
   int failures = 0;
   int fd_count = 0;

   always #5 clk = ~clk;

   ram_single_frame_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
      .ram_do(ram_do), .frame_done(frame_done)
   );

   ram_single_frame_buffer #(.ADDRESS_WIDTH(SAW), .DATA_WIDTH(DW), .FRAME_LEN(SFL)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_data(sm_s_data),
      .m_valid(sm_m_valid), .m_ready(sm_m_ready), .m_data(sm_m_data),
      .ram_en(sm_ram_en), .ram_we(sm_ram_we), .ram_addr(sm_ram_addr), .ram_di(sm_ram_di),
      .ram_do(sm_ram_do), .frame_done(sm_frame_done)
   );

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      for (int i = 0; i < 2**SAW; i++) sm_mem[i] = '0;
   end

   // Behavioural single-port RAMs: read data one cycle after a read enable.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_di;
         else        ram_do <= mem[ram_addr];
      end
      if (sm_ram_en) begin
         if (sm_ram_we) sm_mem[sm_ram_addr] <= sm_ram_di;
         else           sm_ram_do <= sm_mem[sm_ram_addr];
      end
   end

   // One frame: input base+i, expect the same sequence out in order.
   // gaps: random s_valid; rnd_ready: random m_ready with one 10-cycle hold.
   // stop_after: return after that many outputs (used to abort a frame).
   task automatic run_frame(input int base, input bit gaps, input bit rnd_ready, input int stop_after);
      int in_sent = 0, rd_iss = 0, out_done = 0, cycles = 0, hold = 0, last_in = -1000, k;
      bit held = 1'b0, prev_stall = 1'b0, done = 1'b0, exp_en, exp_mv;
      logic signed [DW-1:0] prev_data = '0;
      while (!done) begin
         @(negedge clk);
         if (in_sent < int'(FL)) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = DW'(base + in_sent);
         end else begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
         end
         if (!rnd_ready) m_ready = 1'b1;
         else if (hold > 0) begin m_ready = 1'b0; hold--; end
         else if (out_done == 20 && !held) begin m_ready = 1'b0; hold = 9; held = 1'b1; end
         else m_ready = 1'($urandom_range(0, 1));
         #2;
         checks++;
         if (s_ready !== (in_sent < int'(FL))) begin
            failures++;
            $display("FAIL s_ready: got %b expected %b (base %0d cycle %0d)", s_ready, in_sent < int'(FL), base, cycles);
         end
         if (in_sent < int'(FL)) begin
            if (s_valid) begin
               checks++;
               if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(in_sent) || ram_di !== DW'(base + in_sent)) begin
                  failures++;
                  $display("FAIL fill_write: en=%b we=%b addr=%0d di=%0d expected 1 1 %0d %0d", ram_en, ram_we, ram_addr, ram_di, in_sent, base + in_sent);
               end
               in_sent++;
               if (in_sent == int'(FL)) last_in = cycles;
            end else begin
               checks++;
               if (ram_en !== 1'b0 || ram_we !== 1'b0 || m_valid !== 1'b0) begin
                  failures++;
                  $display("FAIL fill_idle: en=%b we=%b m_valid=%b expected 0 0 0", ram_en, ram_we, m_valid);
               end
            end
         end else begin
            checks++;
            if (ram_we !== 1'b0) begin
               failures++;
               $display("FAIL drain_we: got %b expected 0", ram_we);
            end
            if (!rnd_ready) begin
               k = cycles - last_in;
               exp_en = (k >= 1) && (k <= int'(FL));
               exp_mv = (k >= 3) && (k <= int'(FL) + 2);
               checks++;
               if (ram_en !== exp_en || m_valid !== exp_mv) begin
                  failures++;
                  $display("FAIL drain_timing: k=%0d en=%b m_valid=%b expected %b %b", k, ram_en, m_valid, exp_en, exp_mv);
               end
            end
            if (ram_en === 1'b1) begin
               checks++;
               if (ram_addr !== AW'(rd_iss) || rd_iss >= int'(FL)) begin
                  failures++;
                  $display("FAIL read_addr: got %0d expected %0d", ram_addr, rd_iss);
               end
               rd_iss++;
               checks++;
               if (rd_iss - out_done > 3) begin
                  failures++;
                  $display("FAIL outstanding: got %0d expected <= 3", rd_iss - out_done);
               end
            end
         end
         if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               failures++;
               $display("FAIL stall_hold: m_valid=%b m_data=%0d expected 1 %0d", m_valid, m_data, prev_data);
            end
         end
         if (m_valid === 1'b1 && m_ready) begin
            checks++;
            if (m_data !== DW'(base + out_done) || frame_done !== (out_done == int'(FL) - 1)) begin
               failures++;
               $display("FAIL out_data: m_data=%0d frame_done=%b expected %0d %b", m_data, frame_done, base + out_done, out_done == int'(FL) - 1);
            end
            if (frame_done === 1'b1) fd_count++;
            out_done++;
            if (out_done == int'(FL) || out_done == stop_after) done = 1'b1;
         end else begin
            checks++;
            if (frame_done !== 1'b0) begin
               failures++;
               $display("FAIL spurious_done: got %b expected 0", frame_done);
            end
         end
         prev_stall = (m_valid === 1'b1) && !m_ready;
         prev_data  = m_data;
         cycles++;
         if (cycles > 4000) begin
            failures++;
            $display("FAIL timeout: frame base %0d outputs %0d expected %0d", base, out_done, FL);
            done = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; sm_s_valid = 1'b0; sm_m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_done !== 1'b0 || ram_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_during: s_ready=%b m_valid=%b frame_done=%b ram_en=%b expected 1 0 0 0", s_ready, m_valid, frame_done, ram_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_done !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 ||
          ram_addr !== '0 || ram_di !== '0 || m_data !== '0 || sm_s_ready !== 1'b1 || sm_m_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_after: s_ready=%b m_valid=%b done=%b en=%b we=%b addr=%0d di=%0d m_data=%0d expected 1 0 0 0 0 0 0 0",
                  s_ready, m_valid, frame_done, ram_en, ram_we, ram_addr, ram_di, m_data);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_gaps();
      run_frame(3000, 1'b1, 1'b0, 0);
   endtask

   task automatic test_stall();
      run_frame(2000, 1'b1, 1'b1, 0);
   endtask

   task automatic test_two_frames();
      int fd_before = fd_count;
      run_frame(0, 1'b0, 1'b0, 0);
      run_frame(1000, 1'b0, 1'b0, 0);
      checks++;
      if (fd_count - fd_before != 2) begin
         failures++;
         $display("FAIL two_frames_done: got %0d pulses expected 2", fd_count - fd_before);
      end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(-300, 1'b0, 1'b0, 60);
      @(negedge clk);
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || ram_en !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: m_valid=%b s_ready=%b ram_en=%b frame_done=%b expected 0 1 0 0", m_valid, s_ready, ram_en, frame_done);
      end
      run_frame(500, 1'b0, 1'b0, 0);
   endtask

   task automatic test_small_wrap();
      int sent, rd, got, cyc;
      for (int f = 0; f < 2; f++) begin
         sent = 0; rd = 0; got = 0; cyc = 0;
         while (got < int'(SFL) && cyc < 200) begin
            @(negedge clk);
            sm_s_valid = (sent < int'(SFL));
            sm_s_data  = DW'(10 + f * 100 + sent);
            sm_m_ready = 1'b1;
            #2;
            if (sent < int'(SFL)) begin
               checks++;
               if (sm_s_ready !== 1'b1 || sm_ram_en !== 1'b1 || sm_ram_we !== 1'b1 || sm_ram_addr !== SAW'(sent)) begin
                  failures++;
                  $display("FAIL small_write: ready=%b en=%b we=%b addr=%0d expected 1 1 1 %0d", sm_s_ready, sm_ram_en, sm_ram_we, sm_ram_addr, sent);
               end
               sent++;
            end else begin
               checks++;
               if (sm_s_ready !== 1'b0 || sm_ram_we !== 1'b0) begin
                  failures++;
                  $display("FAIL small_drain: ready=%b we=%b expected 0 0", sm_s_ready, sm_ram_we);
               end
               if (sm_ram_en === 1'b1) begin
                  checks++;
                  if (sm_ram_addr !== SAW'(rd) || rd >= int'(SFL)) begin
                     failures++;
                     $display("FAIL small_read: addr=%0d expected %0d", sm_ram_addr, rd);
                  end
                  rd++;
               end
            end
            if (sm_m_valid === 1'b1) begin
               checks++;
               if (sm_m_data !== DW'(10 + f * 100 + got) || sm_frame_done !== (got == int'(SFL) - 1)) begin
                  failures++;
                  $display("FAIL small_out: m_data=%0d done=%b expected %0d %b", sm_m_data, sm_frame_done, 10 + f * 100 + got, got == int'(SFL) - 1);
               end
               got++;
            end
            cyc++;
         end
         checks++;
         if (got != int'(SFL) || rd != int'(SFL)) begin
            failures++;
            $display("FAIL small_count: outputs=%0d reads=%0d expected %0d %0d", got, rd, SFL, SFL);
         end
      end
      @(negedge clk);
      sm_s_valid = 1'b0;
      #2;
      checks++;
      if (sm_s_ready !== 1'b1 || sm_m_valid !== 1'b0 || sm_ram_en !== 1'b0) begin
         failures++;
         $display("FAIL small_turnover: ready=%b m_valid=%b en=%b expected 1 0 0", sm_s_ready, sm_m_valid, sm_ram_en);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_stall();
      test_two_frames();
      test_reset_mid_frame();
      test_small_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
